mem_port_arbiter: RTL and testbench

- Shares one single-port, word-addressed synchronous SRAM between the fetch stage (read-only) and the memory-access stage (read/write).
- Sits between the pipeline and a unified instruction/data memory.
- Decides one owner per cycle, drives the SRAM, and routes the 1-cycle-latency read data back to the correct requester.
- Denied requesters stall; fetch is protected from starvation by a bounded counter.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/arb_starve_counter.sv | 18 +
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and owner-state encoding for the fetch/data SRAM arbiter
package mem_arb_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_ADDR_W = 6;
    localparam int STARVE_CNT_W = 4;
    typedef logic [1:0] owner_t;
    localparam owner_t NONE = 2'd0;
    localparam owner_t IF_RD = 2'd1;
    localparam owner_t D_RD = 2'd2;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating up-counter with clear, used for starvation and perf counting
module arb_starve_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         at_max
);
    assign at_max = cnt == max;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !at_max) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between fetch (read) and data (read/write) ports
// Optional ARB_PERF_CNT_EN adds saturating conflict_cnt and starve_win_cnt outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WIDTH-1:0]  if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WIDTH-1:0]  d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WIDTH-1:0]  d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       starve_win_cnt
`endif
);
    owner_t owner_q, owner_d;
    logic [STARVE_CNT_W-1:0] starve_q;
    logic starve_hit;
    logic [WIDTH-1:0] if_hold_q, d_hold_q;

    arb_starve_counter #(.W(STARVE_CNT_W)) u_starve (
        .clk(clk), .reset(reset),
        .inc(if_req & !if_gnt), .clr(if_gnt | !if_req),
        .max(STARVE_CNT_W'(STARVE_MAX)),
        .cnt(starve_q), .at_max(starve_hit)
    );

    // Data wins conflicts unless fetch has been denied STARVE_MAX times in a row.
    always_comb begin
        d_gnt = reset & d_req & !(if_req & starve_hit);
        if_gnt = reset & if_req & !d_gnt;
        mem_en = if_gnt | d_gnt;
        mem_we = d_gnt & d_we;
        mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        owner_d = if_gnt ? IF_RD : (d_gnt && !d_we) ? D_RD : NONE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            owner_q <= NONE;
            if_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (if_rvalid) if_hold_q <= mem_rdata;
            if (d_rvalid) d_hold_q <= mem_rdata;
        end

    assign if_rvalid = owner_q == IF_RD;
    assign d_rvalid = owner_q == D_RD;
    assign if_rdata = if_rvalid ? mem_rdata : if_hold_q;
    assign d_rdata = d_rvalid ? mem_rdata : d_hold_q;

`ifdef ARB_PERF_CNT_EN
    logic conflict_sat, starve_win_sat;
    arb_starve_counter #(.W(16)) u_conflict (
        .clk(clk), .reset(reset), .inc(if_req & d_req), .clr(1'b0),
        .max(16'hFFFF), .cnt(conflict_cnt), .at_max(conflict_sat)
    );
    arb_starve_counter #(.W(16)) u_starve_win (
        .clk(clk), .reset(reset), .inc(if_gnt & d_req), .clr(1'b0),
        .max(16'hFFFF), .cnt(starve_win_cnt), .at_max(starve_win_sat)
    );
`else
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a behavioural SRAM
module tb_mem_port_arbiter;
    logic clk = 0, reset = 0;
    logic if_req = 0, if_gnt, if_rvalid;
    logic [5:0] if_addr = 0;
    logic [31:0] if_rdata;
    logic d_req = 0, d_we = 0, d_gnt, d_rvalid;
    logic [5:0] d_addr = 0;
    logic [31:0] d_wdata = 0, d_rdata;
    logic mem_en, mem_we;
    logic [5:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 0;
    logic [31:0] sram [64];
    int n_chk = 0, n_fail = 0;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt, starve_win_cnt;
`endif

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .conflict_cnt(conflict_cnt), .starve_win_cnt(starve_win_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [5:0] a);
        return {16'hC0DE, 10'd0, a};
    endfunction

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else mem_rdata <= sram[mem_addr];
        end

    task automatic test_reset;
        if_req = 1; if_addr = 6'd5;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b want 0 0", if_gnt, d_gnt); end
        n_chk++; if (mem_en !== 1'b0 || mem_addr !== 6'd0) begin n_fail++; $display("FAIL reset_mem: en=%b addr=%0d want 0 0", mem_en, mem_addr); end
        n_chk++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_out: rv=%b%b if_rdata=%h d_rdata=%h want 00 0 0", if_rvalid, d_rvalid, if_rdata, d_rdata); end
        @(negedge clk); reset = 1; #1;
        n_chk++; if (if_gnt !== 1'b1 || mem_addr !== 6'd5 || mem_we !== 1'b0) begin n_fail++; $display("FAIL release_gnt: if_gnt=%b addr=%0d we=%b want 1 5 0", if_gnt, mem_addr, mem_we); end
        @(negedge clk); if_req = 0; #1;
        n_chk++; if (if_rvalid !== 1'b1 || if_rdata !== init_val(6'd5)) begin n_fail++; $display("FAIL release_rd: rv=%b data=%h want 1 %h", if_rvalid, if_rdata, init_val(6'd5)); end
    endtask

    task automatic test_d_read;
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 6'd9; #1;
        n_chk++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'd9) begin n_fail++; $display("FAIL d_read_gnt: d_gnt=%b if_gnt=%b we=%b addr=%0d want 1 0 0 9", d_gnt, if_gnt, mem_we, mem_addr); end
        @(negedge clk); d_req = 0; #1;
        n_chk++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== init_val(6'd9)) begin n_fail++; $display("FAIL d_read_data: rv=%b%b data=%h want 01 %h", if_rvalid, d_rvalid, d_rdata, init_val(6'd9)); end
    endtask

    task automatic test_d_write;
        @(negedge clk); d_req = 1; d_we = 1; d_addr = 6'd3; d_wdata = 32'hDEADBEEF; #1;
        n_chk++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd3 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL d_write_gnt: gnt=%b we=%b addr=%0d wdata=%h want 1 1 3 deadbeef", d_gnt, mem_we, mem_addr, mem_wdata); end
        @(negedge clk); d_req = 0; d_we = 0; d_wdata = 0; #1;
        n_chk++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL d_write_rv: rv=%b%b want 00", if_rvalid, d_rvalid); end
        n_chk++; if (d_rdata !== init_val(6'd9)) begin n_fail++; $display("FAIL d_hold: d_rdata=%h want %h", d_rdata, init_val(6'd9)); end
        if_req = 1; if_addr = 6'd3; #1;
        n_chk++; if (if_gnt !== 1'b1 || mem_wdata !== 32'd0) begin n_fail++; $display("FAIL fetch3_gnt: gnt=%b wdata=%h want 1 0", if_gnt, mem_wdata); end
        @(negedge clk); if_req = 0; #1;
        n_chk++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch3_data: rv=%b data=%h want 1 deadbeef", if_rvalid, if_rdata); end
    endtask

    task automatic test_starve;
        logic prev_if;
        prev_if = 0;
        @(negedge clk); if_req = 1; if_addr = 6'd10; d_req = 1; d_we = 0; d_addr = 6'd11;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_chk++; if (if_gnt !== (i % 4 == 3) || d_gnt !== (i % 4 != 3)) begin n_fail++; $display("FAIL starve_gnt[%0d]: if_gnt=%b d_gnt=%b want %b %b", i, if_gnt, d_gnt, i % 4 == 3, i % 4 != 3); end
            if (i > 0) begin
                n_chk++; if ({if_rvalid, d_rvalid} !== (prev_if ? 2'b10 : 2'b01) || (prev_if ? if_rdata !== init_val(6'd10) : d_rdata !== init_val(6'd11))) begin n_fail++; $display("FAIL starve_rv[%0d]: rv=%b%b if=%h d=%h want prev_if=%b", i, if_rvalid, d_rvalid, if_rdata, d_rdata, prev_if); end
            end
            prev_if = (i % 4 == 3);
            @(negedge clk);
        end
        if_req = 0; d_req = 0; #1;
        n_chk++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== init_val(6'd10)) begin n_fail++; $display("FAIL starve_last: rv=%b%b data=%h want 10 %h", if_rvalid, d_rvalid, if_rdata, init_val(6'd10)); end
`ifdef ARB_PERF_CNT_EN
        n_chk++; if (conflict_cnt !== 16'd8 || starve_win_cnt !== 16'd2) begin n_fail++; $display("FAIL perf_cnt: conflict=%0d win=%0d want 8 2", conflict_cnt, starve_win_cnt); end
`endif
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if_req = (i % 2 == 0); d_req = (i % 2 == 1); d_we = 0;
            if_addr = 6'(20 + i); d_addr = 6'(20 + i);
            #1;
            n_chk++; if (if_gnt !== (i % 2 == 0) || d_gnt !== (i % 2 == 1) || mem_addr !== 6'(20 + i)) begin n_fail++; $display("FAIL b2b_gnt[%0d]: if=%b d=%b addr=%0d", i, if_gnt, d_gnt, mem_addr); end
            if (i > 0) begin
                n_chk++; if ((i % 2 == 1) ? (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== init_val(6'(19 + i)))
                                        : (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== init_val(6'(19 + i)))) begin
                    n_fail++; $display("FAIL b2b_rv[%0d]: rv=%b%b if=%h d=%h want data %h", i, if_rvalid, d_rvalid, if_rdata, d_rdata, init_val(6'(19 + i)));
                end
            end
            @(negedge clk);
        end
        if_req = 0; d_req = 0; #1;
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== init_val(6'd25) || if_rdata !== init_val(6'd24)) begin n_fail++; $display("FAIL b2b_last: rv=%b d=%h if=%h want 1 %h %h", d_rvalid, d_rdata, if_rdata, init_val(6'd25), init_val(6'd24)); end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 6'd9; #1;
        n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: d_gnt=%b want 1", d_gnt); end
        @(posedge clk); #1; d_req = 0; reset = 0; #1;
        n_chk++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rst: rv=%b data=%h want 0 0", d_rvalid, d_rdata); end
`ifdef ARB_PERF_CNT_EN
        n_chk++; if (conflict_cnt !== 16'd0 || starve_win_cnt !== 16'd0) begin n_fail++; $display("FAIL perf_rst: conflict=%0d win=%0d want 0 0", conflict_cnt, starve_win_cnt); end
`endif
        @(negedge clk); reset = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_release[%0d]: rv=%b%b want 00", i, if_rvalid, d_rvalid); end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sram[i] = init_val(6'(i));
        test_reset;
        test_d_read;
        test_d_write;
        test_starve;
        test_back_to_back;
        test_reset_mid_read;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
